// File: rtl/score_keeper_if.sv
// Purpose : bundles the ball-engine win flags, the restart button and the
//           score/segment outputs of score_keeper into one interface.
// Signals : p1_win, p2_win, start  - levels towards the score keeper
//           done, winner           - game-over status back to the ball engine
//           p1_score, p2_score     - raw score registers
//           p1_seg, p2_seg         - active-low {g,f,e,d,c,b,a} digits
// Modports: master drives the flags/button, slave is the score keeper.
interface score_keeper_if #(
  parameter int unsigned SCORE_W = 4
);
  logic               p1_win;
  logic               p2_win;
  logic               start;
  logic               done;
  logic [1:0]         winner;
  logic [SCORE_W-1:0] p1_score;
  logic [SCORE_W-1:0] p2_score;
  logic [6:0]         p1_seg;
  logic [6:0]         p2_seg;

  modport master (
    output p1_win, p2_win, start,
    input  done, winner, p1_score, p2_score, p1_seg, p2_seg
  );

  modport slave (
    input  p1_win, p2_win, start,
    output done, winner, p1_score, p2_score, p1_seg, p2_seg
  );
endinterface

// File: rtl/score_keeper.sv
// Purpose : keeps both players' scores from the ball engine's win flags,
//           declares game over at WIN_SCORE and drives two 7-segment digits.
// Ports   : clk  - pixel clock
//           rst  - synchronous active-high reset
//           sk   - score_keeper_if.slave (win flags, start, done, winner,
//                  scores and active-low segment digits)
// The start level is also the ball engine's reset source; that routing
// lives at the level that instantiates both blocks.
module score_keeper #(
  parameter int unsigned WIN_SCORE = 7,
  parameter int unsigned SCORE_W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  score_keeper_if.slave sk
);

  typedef enum logic {
    PLAY      = 1'b0,
    GAME_OVER = 1'b1
  } state_e;

  localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
  localparam logic [6:0]         SEG_ZERO = 7'b1000000;
  localparam logic [1:0]         WIN_NONE = 2'b00;
  localparam logic [1:0]         WIN_P1   = 2'b01;
  localparam logic [1:0]         WIN_P2   = 2'b10;

  state_e             state_q,      state_d;
  logic [SCORE_W-1:0] p1_score_q,   p1_score_d;
  logic [SCORE_W-1:0] p2_score_q,   p2_score_d;
  logic [1:0]         winner_q,     winner_d;
  logic               done_q,       done_d;
  logic [6:0]         p1_seg_q,     p1_seg_d;
  logic [6:0]         p2_seg_q,     p2_seg_d;
  logic               p1_prev_q,    p1_prev_d;
  logic               p2_prev_q,    p2_prev_d;
  logic               start_prev_q, start_prev_d;

  logic               ev1_c, ev2_c, evs_c;
  logic               p1_only_c, p2_only_c;
  logic [SCORE_W-1:0] p1_inc_c, p2_inc_c;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
  function automatic logic [6:0] seg_decode(input logic [SCORE_W-1:0] v);
    logic [6:0] s;
    case (v)
      SCORE_W'(0): s = 7'b1000000;
      SCORE_W'(1): s = 7'b1111001;
      SCORE_W'(2): s = 7'b0100100;
      SCORE_W'(3): s = 7'b0110000;
      SCORE_W'(4): s = 7'b0011001;
      SCORE_W'(5): s = 7'b0010010;
      SCORE_W'(6): s = 7'b0000010;
      SCORE_W'(7): s = 7'b1111000;
      SCORE_W'(8): s = 7'b0000000;
      SCORE_W'(9): s = 7'b0010000;
      default:     s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Rising-edge detection; simultaneous wins cancel each other.
  always_comb begin
    ev1_c        = sk.p1_win & ~p1_prev_q;
    ev2_c        = sk.p2_win & ~p2_prev_q;
    evs_c        = sk.start  & ~start_prev_q;
    p1_only_c    = ev1_c & ~ev2_c;
    p2_only_c    = ev2_c & ~ev1_c;
    p1_inc_c     = p1_score_q + SCORE_W'(1);
    p2_inc_c     = p2_score_q + SCORE_W'(1);
    p1_prev_d    = sk.p1_win;
    p2_prev_d    = sk.p2_win;
    start_prev_d = sk.start;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PLAY;
      p1_score_q   <= '0;
      p2_score_q   <= '0;
      winner_q     <= WIN_NONE;
      done_q       <= 1'b0;
      p1_seg_q     <= SEG_ZERO;
      p2_seg_q     <= SEG_ZERO;
      // Start high so a level already asserted at release is not an event.
      p1_prev_q    <= 1'b1;
      p2_prev_q    <= 1'b1;
      start_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      p1_score_q   <= p1_score_d;
      p2_score_q   <= p2_score_d;
      winner_q     <= winner_d;
      done_q       <= done_d;
      p1_seg_q     <= p1_seg_d;
      p2_seg_q     <= p2_seg_d;
      p1_prev_q    <= p1_prev_d;
      p2_prev_q    <= p2_prev_d;
      start_prev_q <= start_prev_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PLAY: begin
        if ((p1_only_c && (p1_inc_c == WIN_VAL)) ||
            (p2_only_c && (p2_inc_c == WIN_VAL))) begin
          state_d = GAME_OVER;
        end
      end
      GAME_OVER: begin
        if (evs_c) begin
          state_d = PLAY;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  // Score, winner and done updates; segments decode the current score.
  always_comb begin
    p1_score_d = p1_score_q;
    p2_score_d = p2_score_q;
    winner_d   = winner_q;
    done_d     = done_q;
    p1_seg_d   = seg_decode(p1_score_q);
    p2_seg_d   = seg_decode(p2_score_q);
    case (state_q)
      PLAY: begin
        // Compare before writing so a score can never pass WIN_SCORE.
        if (p1_only_c && (p1_score_q < WIN_VAL)) begin
          p1_score_d = p1_inc_c;
          if (p1_inc_c == WIN_VAL) begin
            done_d   = 1'b1;
            winner_d = WIN_P1;
          end
        end else if (p2_only_c && (p2_score_q < WIN_VAL)) begin
          p2_score_d = p2_inc_c;
          if (p2_inc_c == WIN_VAL) begin
            done_d   = 1'b1;
            winner_d = WIN_P2;
          end
        end
      end
      GAME_OVER: begin
        if (evs_c) begin
          p1_score_d = '0;
          p2_score_d = '0;
          winner_d   = WIN_NONE;
          done_d     = 1'b0;
        end
      end
      default: begin
        p1_score_d = '0;
        p2_score_d = '0;
        winner_d   = WIN_NONE;
        done_d     = 1'b0;
      end
    endcase
  end

  assign sk.done     = done_q;
  assign sk.winner   = winner_q;
  assign sk.p1_score = p1_score_q;
  assign sk.p2_score = p2_score_q;
  assign sk.p1_seg   = p1_seg_q;
  assign sk.p2_seg   = p2_seg_q;

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Scoring stage directly downstream of the ball engine.
- Consumes the ball engine's per-point win flags p1_win and p2_win.
- Keeps both players' scores and drives each score as an active-low 7-segment digit.
- Declares game over by asserting done, which is fed back to the ball engine to park the ball at centre.

Parameters:
- WIN_SCORE, 7, points needed to win; legal range 1..9.
- SCORE_W, 4, width of each score register.

Ports:
- clk  input  1  system clock (25.175 MHz pixel clock domain).
- rst  input  1  synchronous, active-high reset.
- p1_win  input  1  level from ball engine; a 0->1 transition means player 1 scored.
- p2_win  input  1  level from ball engine; a 0->1 transition means player 2 scored.
- start  input  1  debounced restart button, level; a 0->1 transition is the event.
- done  output  1  high while in GAME_OVER.
- winner  output  2  00 = none, 01 = player 1, 10 = player 2.
- p1_score  output  SCORE_W  player 1 score.
- p2_score  output  SCORE_W  player 2 score.
- p1_seg  output  7  active-low segments {g,f,e,d,c,b,a} for p1_score.
- p2_seg  output  7  active-low segments {g,f,e,d,c,b,a} for p2_score.

Behaviour:
- All inputs are synchronous to clk. There are no internal synchronisers.
- Reset values (rst sampled high at a clock edge):
  - state = PLAY
  - p1_score = p2_score = 0
  - winner = 00, done = 0
  - p1_seg = p2_seg = 7'b1000000 ("0")
  - p1_prev, p2_prev, start_prev = 1, so a level already high when reset releases is not counted.
- Edge detect:
  - ev1 = p1_win & ~p1_prev; ev2 = p2_win & ~p2_prev; evs = start & ~start_prev.
  - Prev registers load their inputs every cycle when not in reset.
- States: PLAY and GAME_OVER. The state register, scores, winner and done are all registered.
- PLAY, ev1 only:
  - p1_score increments at the same edge the event is detected. Zero-cycle latency from the sampled edge; visible in the next cycle.
  - If the incremented value equals WIN_SCORE: at that same edge, state -> GAME_OVER, done = 1, winner = 01.
- PLAY, ev2 only: symmetric to ev1, with winner = 10.
- PLAY, ev1 and ev2 in the same cycle: both ignored, no score change (tie-break by discard).
- PLAY, evs: ignored.
- GAME_OVER:
  - Scores frozen; ev1 and ev2 ignored.
  - done stays 1 and winner holds.
  - On evs, at the next edge: scores = 0, winner = 00, done = 0, state -> PLAY.
  - The top level must also route start to the ball engine reset to restore ball speed.
- Scores never exceed WIN_SCORE. The increment path compares before writing, so no wrap-around.
- Segment outputs:
  - Registered decode of the score register, one cycle behind the score.
  - Encoding: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Any other value displays 0111111 ("-").
- rst mid-game or in GAME_OVER overrides every other event in that cycle and returns to the reset values.
- A win flag held high across many cycles counts exactly once. The ball engine holds its flag until its next frame tick.

Test Plan:
- Reset with p1_win already high -> after release p1_score = 0; drop then raise p1_win -> p1_score = 1 and p1_seg = 1111001 one cycle later.
- Hold p2_win high for 2,517,500 cycles after a single rise -> p2_score = 1 exactly, no further increments.
- Seven separate p1_win pulses -> on the 7th detected edge, p1_score = 7, done = 1, winner = 01 in the same cycle; an 8th pulse leaves p1_score = 7.
- p1_win and p2_win rise in the same cycle with scores 3/3 -> scores stay 3/3, done = 0.
- In GAME_OVER (winner = 10, scores 2/7) pulse start -> next cycle scores 0/0, done = 0, winner = 00, state PLAY; a start pulse while in PLAY changes nothing.
- Assert rst for one cycle at scores 5/6 simultaneously with a p2_win rise -> scores 0/0, done = 0, and the p2 edge is not counted.
